// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - Encodings, state type and RAM opcode layout for the memory access sequencer
package mem_ctrl_pkg;

    localparam logic [1:0] KIND_FETCH = 2'b00;
    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_RSVD  = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [2:0] TT_ILLEGAL  = 3'b010;
    localparam logic [2:0] TT_MISALIGN = 3'b011;
    localparam logic [2:0] TT_TIMEOUT  = 3'b100;

    localparam int OP_WRITE_BIT  = 5;
    localparam int OP_SIGNED_BIT = 4;
    localparam int OP_SIZE_LSB   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_MAR,
        ST_LD_MDR,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [5:0] make_opcode(input logic wr, input logic sgn, input logic [1:0] size);
        logic [5:0] op;
        op                              = '0;
        op[OP_WRITE_BIT]                = wr;
        op[OP_SIGNED_BIT]               = sgn;
        op[OP_SIZE_LSB+1:OP_SIZE_LSB]   = size;
        return op;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - Request, RAM handshake and datapath enable bundle for the sequencer
interface mem_access_ctrl_if;
    logic       req;
    logic [1:0] req_kind;
    logic [1:0] req_size;
    logic       req_signed;
    logic [2:0] addr_lo;
    logic       abort;
    logic       MFC;
    logic       MAR_Enable;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       IR_Enable;
    logic       TEMP_Enable;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] err_tt;

    modport master (
        output req, req_kind, req_size, req_signed, addr_lo, abort, MFC,
        input  MAR_Enable, MDR_Enable, MDR_Mux_select, IR_Enable, TEMP_Enable,
               RAM_enable, RAM_OpCode, busy, done, err, err_tt
    );

    modport slave (
        input  req, req_kind, req_size, req_signed, addr_lo, abort, MFC,
        output MAR_Enable, MDR_Enable, MDR_Mux_select, IR_Enable, TEMP_Enable,
               RAM_enable, RAM_OpCode, busy, done, err, err_tt
    );
endinterface

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - Saturating ACCESS-cycle counter with terminal-count flag
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == LAST);
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Sequences MAR/MDR/IR/TEMP loads and RAM strobes for fetch, load and store
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic              Clk,
    input  logic              Clr,
    mem_access_ctrl_if.slave  bus
);
    state_t     state, next_state;
    logic [1:0] kind_q, size_q, eff_size;
    logic       sgn_q;
    logic [2:0] tt_q, tt_d;
    logic       ram_en_q;
    logic [5:0] ram_op_q;
    logic       to_tc;
    logic       mar_en, mdr_en, mdr_sel, ir_en, temp_en;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            SZ_HALF:  return a[0];
            SZ_WORD:  return |a[1:0];
            SZ_DWORD: return |a;
            default:  return 1'b0;
        endcase
    endfunction

    // Instruction fetches are always word accesses regardless of req_size.
    assign eff_size = (kind_q == KIND_FETCH) ? SZ_WORD : size_q;

    mem_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timeout (
        .clk   (Clk),
        .rst_n (Clr),
        .clr   ((state != ST_ACCESS) || bus.abort),
        .en    ((state == ST_ACCESS) && !bus.MFC),
        .tc    (to_tc)
    );

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state    <= ST_IDLE;
            kind_q   <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            tt_q     <= '0;
            ram_en_q <= 1'b0;
            ram_op_q <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && bus.req && !bus.abort) begin
                kind_q <= bus.req_kind;
                size_q <= bus.req_size;
                sgn_q  <= bus.req_signed;
            end
            if (next_state == ST_ERR) begin
                tt_q <= tt_d;
            end
            // RAM strobe and opcode come from flops so the RAM sees no decode glitches.
            ram_en_q <= (next_state == ST_ACCESS);
            ram_op_q <= (next_state == ST_ACCESS)
                      ? make_opcode(kind_q == KIND_STORE, sgn_q && (kind_q != KIND_FETCH), eff_size)
                      : '0;
        end
    end

    always_comb begin
        next_state = state;
        tt_d       = TT_ILLEGAL;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_sel    = 1'b0;
        ir_en      = 1'b0;
        temp_en    = 1'b0;
        if (bus.abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        next_state = (bus.req_kind == KIND_RSVD) ? ST_ERR : ST_LD_MAR;
                    end
                end
                ST_LD_MAR: begin
                    mar_en = 1'b1;
                    if (misaligned(eff_size, bus.addr_lo)) begin
                        next_state = ST_ERR;
                        tt_d       = TT_MISALIGN;
                    end else begin
                        next_state = (kind_q == KIND_STORE) ? ST_LD_MDR : ST_ACCESS;
                    end
                end
                ST_LD_MDR: begin
                    mdr_en     = 1'b1;
                    next_state = ST_ACCESS;
                end
                ST_ACCESS: begin
                    // MFC takes priority over a coincident timeout.
                    if (bus.MFC) begin
                        next_state = ST_DONE;
                        ir_en      = (kind_q == KIND_FETCH);
                        mdr_en     = (kind_q == KIND_LOAD);
                        mdr_sel    = (kind_q == KIND_LOAD);
                        temp_en    = (kind_q == KIND_LOAD) && (size_q == SZ_DWORD);
                    end else if (to_tc) begin
                        next_state = ST_ERR;
                        tt_d       = TT_TIMEOUT;
                    end
                end
                ST_DONE:  next_state = ST_IDLE;
                ST_ERR:   next_state = ST_IDLE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    assign bus.MAR_Enable     = mar_en;
    assign bus.MDR_Enable     = mdr_en;
    assign bus.MDR_Mux_select = mdr_sel;
    assign bus.IR_Enable      = ir_en;
    assign bus.TEMP_Enable    = temp_en;
    assign bus.RAM_enable     = ram_en_q;
    assign bus.RAM_OpCode     = ram_op_q;
    assign bus.busy           = (state != ST_IDLE);
    assign bus.done           = (state == ST_DONE);
    assign bus.err            = (state == ST_ERR);
    assign bus.err_tt         = (state == ST_ERR) ? tt_q : 3'b000;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Scoreboard bench for mem_access_ctrl request sequencing
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int TO = 15;

    typedef struct {
        logic       is_err;
        logic [2:0] tt;
        int         at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .Clk (clk),
        .Clr (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req        = 1'b0;
        bus.req_kind   = 2'b00;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.addr_lo    = 3'b000;
        bus.abort      = 1'b0;
        bus.MFC        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.MAR_Enable, bus.MDR_Enable, bus.MDR_Mux_select, bus.IR_Enable,
                    bus.TEMP_Enable, bus.RAM_enable, bus.RAM_OpCode, bus.busy,
                    bus.done, bus.err, bus.err_tt}, 32'h0);
    endtask

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n && (bus.done || bus.err)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {bus.done, bus.err}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("sb_err", bus.err, e.is_err);
                check("sb_done", bus.done, !e.is_err);
                check("sb_tt", bus.err_tt, e.tt);
                check("sb_cycle", cyc, e.at);
            end
        end
    end

    // wait_n: ACCESS cycles without MFC before MFC rises; >= TO means MFC never comes.
    task automatic run_req(input logic [1:0] kind, input logic [1:0] size, input logic sgn,
                           input logic [2:0] addr, input int wait_n);
        logic [1:0] esz;
        logic       legal, misal, is_err, in_acc, cap, exp_mdr;
        logic [2:0] tt;
        logic [5:0] op;
        int         acc, last;
        legal  = (kind != 2'b11);
        esz    = (kind == KIND_FETCH) ? SZ_WORD : size;
        misal  = legal && ((esz == SZ_HALF && addr[0]) ||
                           (esz == SZ_WORD && addr[1:0] != 2'b00) ||
                           (esz == SZ_DWORD && addr != 3'b000));
        acc    = (kind == KIND_STORE) ? 3 : 2;
        op     = {kind == KIND_STORE, (kind == KIND_FETCH) ? 1'b0 : sgn, esz, 2'b00};
        if (!legal) begin
            is_err = 1'b1; tt = 3'b010; last = 1;
        end else if (misal) begin
            is_err = 1'b1; tt = 3'b011; last = 2;
        end else if (wait_n >= TO) begin
            is_err = 1'b1; tt = 3'b100; last = acc + TO;
        end else begin
            is_err = 1'b0; tt = 3'b000; last = acc + wait_n + 1;
        end
        for (int t = 0; t <= last + 1; t++) begin
            next_cycle();
            if (t == 0) sb.push_back('{is_err, tt, cyc + last});
            cap     = !is_err && (t == acc + wait_n);
            in_acc  = legal && !misal && (t >= acc) && (t < last);
            exp_mdr = (kind == KIND_STORE && !misal && t == 2) || (kind == KIND_LOAD && cap);
            bus.req        = (t <= last);
            bus.req_kind   = (t == 0) ? kind : ~kind;
            bus.req_size   = (t == 0) ? size : ~size;
            bus.req_signed = (t == 0) ? sgn : ~sgn;
            bus.addr_lo    = (t == 1) ? addr : ~addr;
            bus.MFC        = cap;
            @(negedge clk);
            check("mar_en", bus.MAR_Enable, legal && t == 1);
            check("mdr_en", bus.MDR_Enable, exp_mdr);
            if (exp_mdr) check("mdr_sel", bus.MDR_Mux_select, kind == KIND_LOAD);
            check("ir_en", bus.IR_Enable, kind == KIND_FETCH && cap);
            check("temp_en", bus.TEMP_Enable, kind == KIND_LOAD && cap && size == SZ_DWORD);
            check("ram_en", bus.RAM_enable, in_acc);
            if (in_acc) check("ram_op", bus.RAM_OpCode, op);
            check("busy", bus.busy, t >= 1 && t <= last);
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;

        run_req(KIND_LOAD,  SZ_WORD,  1'b0, 3'b000, 0);
        run_req(KIND_STORE, SZ_HALF,  1'b0, 3'b010, 2);
        run_req(KIND_LOAD,  SZ_WORD,  1'b0, 3'b010, 0);
        run_req(KIND_FETCH, SZ_BYTE,  1'b1, 3'b100, TO);
        run_req(KIND_LOAD,  SZ_DWORD, 1'b0, 3'b000, 0);
        run_req(KIND_LOAD,  SZ_BYTE,  1'b1, 3'b111, 3);
        run_req(KIND_LOAD,  SZ_HALF,  1'b1, 3'b001, 0);
        run_req(KIND_STORE, SZ_DWORD, 1'b0, 3'b100, 0);
        run_req(KIND_RSVD,  SZ_WORD,  1'b0, 3'b000, 0);

        // abort coinciding with MFC in ACCESS
        next_cycle();
        bus.req = 1'b1; bus.req_kind = KIND_LOAD; bus.req_size = SZ_WORD;
        @(negedge clk);
        next_cycle();
        bus.req = 1'b0; bus.addr_lo = 3'b000;
        @(negedge clk);
        check("ab_mar", bus.MAR_Enable, 1'b1);
        next_cycle();
        @(negedge clk);
        check("ab_ram", bus.RAM_enable, 1'b1);
        next_cycle();
        bus.MFC = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        check("ab_cap", {bus.MAR_Enable, bus.MDR_Enable, bus.IR_Enable, bus.TEMP_Enable}, 32'h0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("ab_idle", bus.busy, 1'b0);
        check("ab_ram_off", bus.RAM_enable, 1'b0);
        next_cycle();
        @(negedge clk);

        // MFC on the same cycle the timeout would fire
        run_req(KIND_FETCH, SZ_WORD, 1'b0, 3'b000, TO - 1);

        // Clr pulsed mid-store
        next_cycle();
        bus.req = 1'b1; bus.req_kind = KIND_STORE; bus.req_size = SZ_WORD;
        @(negedge clk);
        next_cycle();
        bus.req = 1'b0; bus.addr_lo = 3'b000;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("clr_ld_mdr", bus.MDR_Enable, 1'b1);
        next_cycle();
        @(negedge clk);
        check("clr_access", bus.RAM_enable, 1'b1);
        next_cycle();
        #2 rst_n = 1'b0;
        #1 check_all_zero("clr_async");
        @(negedge clk);
        check_all_zero("clr_hold");
        next_cycle();
        rst_n = 1'b1;
        run_req(KIND_LOAD, SZ_WORD, 1'b0, 3'b100, 1);

        repeat (3) next_cycle();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
